obi_copy_engine: RTL

- Single-channel OBI manager (initiator) that copies a block of 32-bit words from a source address to a destination address.
- Offloads the flash-to-SRAM copy loop from the core: each word is read from the source region, then written to the destination region.
- Sits on the SoC crossbar as an additional OBI manager port. Software or boot logic starts it via a start pulse.
- One OBI transaction outstanding at a time; strictly read-then-write per word.

---
 rtl/obi_copy_pkg.sv | 19 +
 rtl/obi_copy_engine_if.sv | 27 ++
 rtl/obi_copy_engine.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/obi_copy_pkg.sv
// Shared definitions for the OBI block-copy engine.
//   obi_copy_state_e : controller state encoding
//   OBI_BE_WORD      : byte enable used for every (full-word) access
//   WORD_BYTES       : address step between consecutive words
package obi_copy_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_RSP,
    WR_REQ,
    WR_RSP,
    DONE
  } obi_copy_state_e;

  localparam logic [3:0] OBI_BE_WORD = 4'hF;
  localparam int         WORD_BYTES  = 4;

endpackage

// File: rtl/obi_copy_engine_if.sv
// OBI bus bundle between the copy engine (master) and the crossbar (slave).
//   req/addr/we/be/wdata : request channel, driven by the manager
//   gnt                  : request accepted by the fabric
//   rvalid/rdata/err     : response channel; err is only meaningful with rvalid
interface obi_copy_engine_if;

  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata, err
  );

endinterface

// File: rtl/obi_copy_engine.sv
// Single-channel OBI manager that copies len_i 32-bit words from src_addr_i
// to dst_addr_i, one outstanding transaction at a time, read then write per
// word.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   start_i           : start request, only looked at while idle
//   src_addr_i        : source byte address (low two bits ignored)
//   dst_addr_i        : destination byte address (low two bits ignored)
//   len_i             : number of words; zero completes with no bus traffic
//   busy_o            : transfer in progress
//   done_o            : one-cycle pulse at completion or abort
//   error_o           : sticky error flag, cleared by the next accepted start
//   obi               : OBI manager port
module obi_copy_engine
  import obi_copy_pkg::*;
#(
  parameter int LEN_WIDTH     = 10,
  parameter bit OBI_ERR_ABORT = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [31:0]          src_addr_i,
  input  logic [31:0]          dst_addr_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  obi_copy_engine_if.master    obi
);

  localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFFC;

  obi_copy_state_e      state_q;
  logic [31:0]          src_q;
  logic [31:0]          dst_q;
  logic [LEN_WIDTH-1:0] rem_q;
  logic                 req_q;
  logic                 we_q;
  logic [31:0]          addr_q;
  logic [31:0]          wdata_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 error_q;

  logic                 rd_fire;
  logic                 wr_fire;
  logic                 rsp_abort;
  logic [31:0]          src_nxt;
  logic [31:0]          dst_nxt;

  // A response counts either in the *_RSP state or together with the grant
  // (zero-latency responders); a lone rvalid anywhere else is ignored.
  assign rd_fire   = obi.rvalid && ((state_q == RD_REQ && obi.gnt) || state_q == RD_RSP);
  assign wr_fire   = obi.rvalid && ((state_q == WR_REQ && obi.gnt) || state_q == WR_RSP);
  assign rsp_abort = obi.err && OBI_ERR_ABORT;

  // Address arithmetic wraps modulo 2^32.
  assign src_nxt = src_q + 32'(WORD_BYTES);
  assign dst_nxt = dst_q + 32'(WORD_BYTES);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            error_q <= 1'b0;
            if (len_i != '0) begin
              src_q   <= src_addr_i & ADDR_MASK;
              dst_q   <= dst_addr_i & ADDR_MASK;
              rem_q   <= len_i;
              addr_q  <= src_addr_i & ADDR_MASK;
              req_q   <= 1'b1;
              we_q    <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= RD_REQ;
            end else begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end

        RD_REQ, RD_RSP: begin
          if (rd_fire) begin
            wdata_q <= obi.rdata;
            if (obi.err) error_q <= 1'b1;
            if (rsp_abort) begin
              req_q   <= 1'b0;
              we_q    <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              // Errored data is still written when aborting is disabled.
              req_q   <= 1'b1;
              we_q    <= 1'b1;
              addr_q  <= dst_q;
              state_q <= WR_REQ;
            end
          end else if (state_q == RD_REQ && obi.gnt) begin
            req_q   <= 1'b0;
            state_q <= RD_RSP;
          end
        end

        WR_REQ, WR_RSP: begin
          if (wr_fire) begin
            if (obi.err) error_q <= 1'b1;
            src_q <= src_nxt;
            dst_q <= dst_nxt;
            rem_q <= rem_q - LEN_WIDTH'(1);
            if (rsp_abort || rem_q == LEN_WIDTH'(1)) begin
              req_q   <= 1'b0;
              we_q    <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              req_q   <= 1'b1;
              we_q    <= 1'b0;
              addr_q  <= src_nxt;
              state_q <= RD_REQ;
            end
          end else if (state_q == WR_REQ && obi.gnt) begin
            req_q   <= 1'b0;
            state_q <= WR_RSP;
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign error_o   = error_q;
  assign obi.req   = req_q;
  assign obi.we    = we_q;
  assign obi.addr  = addr_q;
  assign obi.wdata = wdata_q;
  assign obi.be    = OBI_BE_WORD;

endmodule
